// File: rtl/spell_dbg_host.sv
// Host-side master for the SPELL core's serial debug port.
// Turns a parallel command stream (write/read register, run, step) into the
// bit-level pin sequences the core samples on ui_in, deserialises dump data
// from the core's shift-out pin and reports the core's stop status.
//
// All outputs come straight from flops. The next-state logic computes the
// state for the coming cycle, and the pin values are decoded from that next
// state, so each pin changes on the same edge that the state does.
//
//  state     | meaning
//  ----------+------------------------------------------------------------
//  IDLE      | ready for a command (cmd_ready high)
//  SHIFT     | write data shifted out on dbg_shift_in, MSB first, 8 cycles
//  LOAD      | dbg_load pulse, core latches the shifted byte
//  DUMP      | dbg_dump pulse, core starts presenting the selected register
//  GAP       | wait for the core's capture/output pipeline to fill
//  CAPTURE   | sample dbg_shift_out, MSB first, 8 cycles
//  RUN       | dbg_run pulse (with dbg_step for STEP)
//  GUARD     | 2 cycles with dbg_stop ignored while the core leaves Stop/Sleep
//  WAIT_STOP | wait for dbg_stop, bounded by TIMEOUT
//  RESP      | rsp_valid pulse
module spell_dbg_host #(
   parameter int SAMPLE_DELAY = 2,
   parameter int TIMEOUT      = 50000,
   parameter int TIMEOUT_W    = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_op,
   input  logic [1:0] cmd_reg,
   input  logic [7:0] cmd_data,
   input  logic       cmd_wait,
   output logic       rsp_valid,
   output logic [7:0] rsp_data,
   output logic       rsp_timeout,
   output logic       dbg_run,
   output logic       dbg_step,
   output logic       dbg_load,
   output logic       dbg_dump,
   output logic       dbg_shift_in,
   output logic [1:0] dbg_reg_sel,
   input  logic       dbg_shift_out,
   input  logic       dbg_stop
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_SHIFT,
      S_LOAD,
      S_DUMP,
      S_GAP,
      S_CAPTURE,
      S_RUN,
      S_GUARD,
      S_WAIT_STOP,
      S_RESP
   } state_t;

   localparam logic [1:0] OP_WRITE = 2'd0;
   localparam logic [1:0] OP_READ  = 2'd1;
   localparam logic [1:0] OP_RUN   = 2'd2;
   localparam logic [1:0] OP_STEP  = 2'd3;
   localparam logic [1:0] REG_EXEC = 2'd2;

   localparam logic [TIMEOUT_W-1:0] CNT_ONE        = TIMEOUT_W'(1);
   localparam logic [TIMEOUT_W-1:0] CNT_BIT_LAST   = TIMEOUT_W'(7);
   localparam logic [TIMEOUT_W-1:0] CNT_GUARD_LAST = TIMEOUT_W'(1);
   localparam logic [TIMEOUT_W-1:0] CNT_GAP_LAST   =
      TIMEOUT_W'((SAMPLE_DELAY >= 2) ? (SAMPLE_DELAY - 2) : 0);
   localparam logic [TIMEOUT_W-1:0] CNT_TO_LAST    = TIMEOUT_W'(TIMEOUT - 1);

   state_t                state_q, state_d;
   logic [TIMEOUT_W-1:0]  cnt_q, cnt_d;
   logic [1:0]            op_q, op_d;
   logic [1:0]            reg_q, reg_d;
   logic [7:0]            data_q, data_d;
   logic                  wait_q, wait_d;
   logic [6:0]            cap_q, cap_d;
   logic                  timeout_d;

   logic                  cmd_ready_q, cmd_ready_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic [7:0]            rsp_data_q, rsp_data_d;
   logic                  rsp_timeout_q, rsp_timeout_d;
   logic                  run_q, run_d;
   logic                  step_q, step_d;
   logic                  load_q, load_d;
   logic                  dump_q, dump_d;
   logic                  shin_q, shin_d;
   logic [1:0]            sel_q, sel_d;

   // Sequencer: next state, counters, latched command and capture shifter.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      reg_d     = reg_q;
      data_d    = data_q;
      wait_d    = wait_q;
      cap_d     = cap_q;
      timeout_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               op_d   = cmd_op;
               reg_d  = cmd_reg;
               data_d = cmd_data;
               wait_d = cmd_wait;
               cnt_d  = '0;
               case (cmd_op)
                  OP_WRITE: state_d = S_SHIFT;
                  OP_READ:  state_d = S_DUMP;
                  default:  state_d = S_RUN;
               endcase
            end
         end
         S_SHIFT: begin
            if (cnt_q == CNT_BIT_LAST) begin
               state_d = S_LOAD;
               cnt_d   = '0;
            end else begin
               cnt_d  = cnt_q + CNT_ONE;
               data_d = {data_q[6:0], 1'b0};
            end
         end
         S_LOAD: begin
            // Only an EXEC write runs code, so only it has a stop to wait for.
            cnt_d = '0;
            if (wait_q && (reg_q == REG_EXEC)) begin
               state_d = S_GUARD;
            end else begin
               state_d = S_RESP;
            end
         end
         S_DUMP: begin
            cnt_d = '0;
            if (SAMPLE_DELAY == 1) begin
               state_d = S_CAPTURE;
            end else begin
               state_d = S_GAP;
            end
         end
         S_GAP: begin
            if (cnt_q == CNT_GAP_LAST) begin
               state_d = S_CAPTURE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         S_CAPTURE: begin
            cap_d = {cap_q[5:0], dbg_shift_out};
            if (cnt_q == CNT_BIT_LAST) begin
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         S_RUN: begin
            cnt_d = '0;
            if (wait_q) begin
               state_d = S_GUARD;
            end else begin
               state_d = S_RESP;
            end
         end
         S_GUARD: begin
            if (cnt_q == CNT_GUARD_LAST) begin
               state_d = S_WAIT_STOP;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         S_WAIT_STOP: begin
            // A stop seen in the final counted cycle still counts as a stop.
            if (dbg_stop) begin
               state_d = S_RESP;
            end else if (cnt_q == CNT_TO_LAST) begin
               state_d   = S_RESP;
               timeout_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Pin values for the coming cycle, decoded from the next state.
   always_comb begin
      cmd_ready_d   = (state_d == S_IDLE);
      rsp_valid_d   = (state_d == S_RESP);
      rsp_timeout_d = (state_d == S_RESP) && timeout_d;
      rsp_data_d    = rsp_data_q;
      if (state_d == S_RESP) begin
         rsp_data_d = (op_q == OP_READ) ? {cap_q, dbg_shift_out} : 8'h00;
      end
      run_d  = (state_d == S_RUN);
      // dbg_step stays up one cycle past the run pulse.
      step_d = (op_d == OP_STEP) && ((state_d == S_RUN) || (state_q == S_RUN));
      load_d = (state_d == S_LOAD);
      dump_d = (state_d == S_DUMP);
      shin_d = (state_d == S_SHIFT) ? data_d[7] : 1'b0;
      sel_d  = ((state_d == S_IDLE) || (state_d == S_RESP)) ? 2'd0 : reg_d;
   end

   // Sequencer state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         op_q    <= 2'd0;
         reg_q   <= 2'd0;
         data_q  <= 8'h00;
         wait_q  <= 1'b0;
         cap_q   <= 7'h00;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         reg_q   <= reg_d;
         data_q  <= data_d;
         wait_q  <= wait_d;
         cap_q   <= cap_d;
      end
   end

   // Output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cmd_ready_q   <= 1'b1;
         rsp_valid_q   <= 1'b0;
         rsp_data_q    <= 8'h00;
         rsp_timeout_q <= 1'b0;
         run_q         <= 1'b0;
         step_q        <= 1'b0;
         load_q        <= 1'b0;
         dump_q        <= 1'b0;
         shin_q        <= 1'b0;
         sel_q         <= 2'd0;
      end else begin
         cmd_ready_q   <= cmd_ready_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_data_q    <= rsp_data_d;
         rsp_timeout_q <= rsp_timeout_d;
         run_q         <= run_d;
         step_q        <= step_d;
         load_q        <= load_d;
         dump_q        <= dump_d;
         shin_q        <= shin_d;
         sel_q         <= sel_d;
      end
   end

   assign cmd_ready    = cmd_ready_q;
   assign rsp_valid    = rsp_valid_q;
   assign rsp_data     = rsp_data_q;
   assign rsp_timeout  = rsp_timeout_q;
   assign dbg_run      = run_q;
   assign dbg_step     = step_q;
   assign dbg_load     = load_q;
   assign dbg_dump     = dump_q;
   assign dbg_shift_in = shin_q;
   assign dbg_reg_sel  = sel_q;

endmodule

// File: tb/tb_spell_dbg_host.sv
// Directed bench for spell_dbg_host with a small behavioural SPELL debug-port
// model (shift-in register, load into PC/SP/EXEC/stack, dump with a 2-deep
// pipeline, stop flag that drops for a few cycles after an EXEC load).
module tb_spell_dbg_host;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [1:0] cmd_reg;
   logic [7:0] cmd_data;
   logic       cmd_wait;
   logic       rsp_valid;
   logic [7:0] rsp_data;
   logic       rsp_timeout;
   logic       dbg_run;
   logic       dbg_step;
   logic       dbg_load;
   logic       dbg_dump;
   logic       dbg_shift_in;
   logic [1:0] dbg_reg_sel;
   logic       dbg_shift_out;
   logic       dbg_stop;

   int n_checks = 0;
   int n_fail   = 0;

   spell_dbg_host #(
      .SAMPLE_DELAY(2),
      .TIMEOUT     (20),
      .TIMEOUT_W   (16)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_op       (cmd_op),
      .cmd_reg      (cmd_reg),
      .cmd_data     (cmd_data),
      .cmd_wait     (cmd_wait),
      .rsp_valid    (rsp_valid),
      .rsp_data     (rsp_data),
      .rsp_timeout  (rsp_timeout),
      .dbg_run      (dbg_run),
      .dbg_step     (dbg_step),
      .dbg_load     (dbg_load),
      .dbg_dump     (dbg_dump),
      .dbg_shift_in (dbg_shift_in),
      .dbg_reg_sel  (dbg_reg_sel),
      .dbg_shift_out(dbg_shift_out),
      .dbg_stop     (dbg_stop)
   );

   always #5 clk = ~clk;

   // ---------------- core model ----------------
   logic [7:0] core_pc    = 8'h00;
   logic [7:0] core_sp    = 8'h00;
   logic [7:0] core_exec  = 8'h00;
   logic [7:0] core_shin  = 8'h00;
   logic [7:0] core_shout = 8'h00;
   logic [7:0] core_stk [0:15];
   logic       core_so    = 1'b0;
   logic       core_stop  = 1'b1;
   logic       force_stop_low = 1'b0;
   int         core_busy  = 0;
   logic [7:0] sp_m1;

   assign sp_m1         = core_sp - 8'd1;
   assign dbg_shift_out = core_so;
   assign dbg_stop      = force_stop_low ? 1'b0 : core_stop;

   always @(posedge clk) begin
      core_shin <= {core_shin[6:0], dbg_shift_in};
      core_so   <= core_shout[7];
      if (dbg_dump) begin
         case (dbg_reg_sel)
            2'd0:    core_shout <= core_pc;
            2'd1:    core_shout <= core_sp;
            2'd2:    core_shout <= core_exec;
            default: core_shout <= core_stk[sp_m1[3:0]];
         endcase
      end else begin
         core_shout <= {core_shout[6:0], 1'b0};
      end
      if (dbg_load) begin
         case (dbg_reg_sel)
            2'd0: core_pc <= core_shin;
            2'd1: core_sp <= core_shin;
            2'd2: begin
               core_exec <= core_shin;
               core_stop <= 1'b0;
               core_busy <= 3;
            end
            default: begin
               core_stk[core_sp[3:0]] <= core_shin;
               core_sp <= core_sp + 8'd1;
            end
         endcase
      end else if (core_busy != 0) begin
         core_busy <= core_busy - 1;
         if (core_busy == 1) core_stop <= 1'b1;
      end
   end

   // ---------------- recording ----------------
   logic [31:0] m_load, m_dump, m_run, m_step, m_rv, m_rdy, m_shin;
   logic [1:0]  m_sel [0:31];
   int          rec_cyc;
   logic [7:0]  rec_data;
   logic        rec_to;

   task automatic start_cmd(input logic [1:0] op, input logic [1:0] rg,
                            input logic [7:0] d, input logic w);
      @(negedge clk);
      cmd_op    = op;
      cmd_reg   = rg;
      cmd_data  = d;
      cmd_wait  = w;
      cmd_valid = 1'b1;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   // Samples pins at the negedge of cycles 0..n-1 after acceptance.
   task automatic record(input int n);
      m_load = '0; m_dump = '0; m_run = '0; m_step = '0;
      m_rv = '0; m_rdy = '0; m_shin = '0;
      rec_cyc = -1; rec_data = 8'h00; rec_to = 1'b0;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         m_load[k] = dbg_load;
         m_dump[k] = dbg_dump;
         m_run[k]  = dbg_run;
         m_step[k] = dbg_step;
         m_rv[k]   = rsp_valid;
         m_rdy[k]  = cmd_ready;
         m_shin[k] = dbg_shift_in;
         m_sel[k]  = dbg_reg_sel;
         if (rsp_valid === 1'b1 && rec_cyc < 0) begin
            rec_cyc  = k;
            rec_data = rsp_data;
            rec_to   = rsp_timeout;
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      #1;
      n_checks++;
      if ({cmd_ready, rsp_valid, rsp_timeout, rsp_data} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
         n_fail++;
         $display("FAIL reset_rsp: got rdy=%b rv=%b to=%b data=%h expected 1 0 0 00",
                  cmd_ready, rsp_valid, rsp_timeout, rsp_data);
      end
      n_checks++;
      if ({dbg_run, dbg_step, dbg_load, dbg_dump, dbg_shift_in, dbg_reg_sel} !== 7'b0) begin
         n_fail++;
         $display("FAIL reset_dbg: got %b expected 0000000",
                  {dbg_run, dbg_step, dbg_load, dbg_dump, dbg_shift_in, dbg_reg_sel});
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (cmd_ready !== 1'b1 || dbg_load !== 1'b0 || rsp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: got rdy=%b load=%b rv=%b expected 1 0 0",
                  cmd_ready, dbg_load, rsp_valid);
      end
   endtask

   task automatic test_write_pc();
      start_cmd(2'd0, 2'd0, 8'hA5, 1'b0);
      record(16);
      n_checks++;
      if (m_shin[15:0] !== 16'h00A5) begin
         n_fail++; $display("FAIL wr_shift_in: got %h expected %h", m_shin[15:0], 16'h00A5);
      end
      n_checks++;
      if (m_load[15:0] !== 16'h0100) begin
         n_fail++; $display("FAIL wr_load: got %h expected %h", m_load[15:0], 16'h0100);
      end
      n_checks++;
      if (m_sel[8] !== 2'd0) begin
         n_fail++; $display("FAIL wr_sel: got %0d expected 0", m_sel[8]);
      end
      n_checks++;
      if (m_rv[15:0] !== 16'h0200 || rec_data !== 8'h00) begin
         n_fail++; $display("FAIL wr_rsp: got rv=%h data=%h expected 0200 00", m_rv[15:0], rec_data);
      end
      n_checks++;
      if (m_rdy[15:0] !== 16'hFC00) begin
         n_fail++; $display("FAIL wr_ready: got %h expected %h", m_rdy[15:0], 16'hFC00);
      end
   endtask

   task automatic test_read_sp();
      start_cmd(2'd0, 2'd1, 8'h13, 1'b0);
      record(16);
      n_checks++;
      if (m_sel[8] !== 2'd1 || m_load[15:0] !== 16'h0100) begin
         n_fail++; $display("FAIL wr_sp: got sel=%0d load=%h expected 1 0100", m_sel[8], m_load[15:0]);
      end
      start_cmd(2'd1, 2'd1, 8'h00, 1'b0);
      record(16);
      n_checks++;
      if (m_dump[15:0] !== 16'h0001) begin
         n_fail++; $display("FAIL rd_dump: got %h expected %h", m_dump[15:0], 16'h0001);
      end
      n_checks++;
      if (m_rv[15:0] !== 16'h0400) begin
         n_fail++; $display("FAIL rd_rsp_cycle: got %h expected %h", m_rv[15:0], 16'h0400);
      end
      n_checks++;
      if (rec_data !== 8'h13 || rec_to !== 1'b0) begin
         n_fail++; $display("FAIL rd_data: got %h to=%b expected 13 0", rec_data, rec_to);
      end
      n_checks++;
      if (m_load[15:0] !== 16'h0 || m_shin[15:0] !== 16'h0 || m_rdy[15:0] !== 16'hF800) begin
         n_fail++; $display("FAIL rd_quiet: got load=%h shin=%h rdy=%h expected 0 0 f800",
                            m_load[15:0], m_shin[15:0], m_rdy[15:0]);
      end
      n_checks++;
      if (rsp_data !== 8'h13) begin
         n_fail++; $display("FAIL rd_hold: got %h expected 13", rsp_data);
      end
   endtask

   task automatic test_round_trip();
      start_cmd(2'd0, 2'd1, 8'h00, 1'b0);
      record(16);
      start_cmd(2'd0, 2'd3, 8'h3C, 1'b0);
      record(16);
      start_cmd(2'd1, 2'd3, 8'h00, 1'b0);
      record(16);
      n_checks++;
      if (rec_data !== 8'h3C || rec_cyc != 10) begin
         n_fail++; $display("FAIL rt_stack: got %h at %0d expected 3c at 10", rec_data, rec_cyc);
      end
      start_cmd(2'd1, 2'd1, 8'h00, 1'b0);
      record(16);
      n_checks++;
      if (rec_data !== 8'h01) begin
         n_fail++; $display("FAIL rt_sp: got %h expected 01", rec_data);
      end
   endtask

   task automatic test_exec_wait();
      start_cmd(2'd0, 2'd2, 8'h7A, 1'b1);
      record(24);
      n_checks++;
      if (rec_cyc != 13 || rec_to !== 1'b0) begin
         n_fail++; $display("FAIL exec_rsp: got cycle %0d to=%b expected 13 0", rec_cyc, rec_to);
      end
      n_checks++;
      if (m_load[23:0] !== 24'h000100 || m_run[23:0] !== 24'h0) begin
         n_fail++; $display("FAIL exec_pins: got load=%h run=%h expected 000100 000000",
                            m_load[23:0], m_run[23:0]);
      end
   endtask

   task automatic test_timeout();
      force_stop_low = 1'b1;
      start_cmd(2'd2, 2'd0, 8'h00, 1'b1);
      record(30);
      n_checks++;
      if (rec_cyc != 23 || rec_to !== 1'b1 || rec_data !== 8'h00) begin
         n_fail++; $display("FAIL to_rsp: got cycle %0d to=%b data=%h expected 23 1 00",
                            rec_cyc, rec_to, rec_data);
      end
      n_checks++;
      if (m_run[29:0] !== 30'h1 || m_step[29:0] !== 30'h0) begin
         n_fail++; $display("FAIL to_run: got run=%h step=%h expected 1 0", m_run[29:0], m_step[29:0]);
      end
      // STEP without wait: run in cycle 0, step in cycles 0-1, response in cycle 1.
      start_cmd(2'd3, 2'd0, 8'h00, 1'b0);
      record(8);
      n_checks++;
      if (m_run[7:0] !== 8'h01 || m_step[7:0] !== 8'h03) begin
         n_fail++; $display("FAIL step_pins: got run=%h step=%h expected 01 03", m_run[7:0], m_step[7:0]);
      end
      n_checks++;
      if (rec_cyc != 1 || rec_to !== 1'b0 || m_rdy[7:0] !== 8'hFC) begin
         n_fail++; $display("FAIL step_rsp: got cycle %0d to=%b rdy=%h expected 1 0 fc",
                            rec_cyc, rec_to, m_rdy[7:0]);
      end
      // Stop arriving in the very cycle the counter expires is a stop, not a timeout.
      start_cmd(2'd2, 2'd0, 8'h00, 1'b1);
      rec_cyc = -1; rec_to = 1'b0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (k == 22) force_stop_low = 1'b0;
         if (rsp_valid === 1'b1 && rec_cyc < 0) begin
            rec_cyc = k;
            rec_to  = rsp_timeout;
         end
      end
      force_stop_low = 1'b0;
      n_checks++;
      if (rec_cyc != 23 || rec_to !== 1'b0) begin
         n_fail++; $display("FAIL stop_wins: got cycle %0d to=%b expected 23 0", rec_cyc, rec_to);
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      cmd_op = 2'd0; cmd_reg = 2'd0; cmd_data = 8'h11; cmd_wait = 1'b0;
      cmd_valid = 1'b1;
      @(posedge clk);
      m_load = '0; m_rv = '0; m_rdy = '0;
      for (int k = 0; k < 24; k++) begin
         @(negedge clk);
         if (k == 12) cmd_valid = 1'b0;
         m_load[k] = dbg_load;
         m_rv[k]   = rsp_valid;
         m_rdy[k]  = cmd_ready;
      end
      n_checks++;
      if (m_load[23:0] !== 24'h080100) begin
         n_fail++; $display("FAIL b2b_load: got %h expected %h", m_load[23:0], 24'h080100);
      end
      n_checks++;
      if (m_rv[23:0] !== 24'h100200) begin
         n_fail++; $display("FAIL b2b_rsp: got %h expected %h", m_rv[23:0], 24'h100200);
      end
      n_checks++;
      if (m_rdy[23:0] !== 24'hE00400) begin
         n_fail++; $display("FAIL b2b_ready: got %h expected %h", m_rdy[23:0], 24'hE00400);
      end
   endtask

   task automatic test_reset_mid();
      start_cmd(2'd1, 2'd0, 8'h00, 1'b0);
      record(5);
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_checks++;
      if ({cmd_ready, rsp_valid, rsp_timeout, rsp_data} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
         n_fail++; $display("FAIL mid_rst_rsp: got rdy=%b rv=%b to=%b data=%h expected 1 0 0 00",
                            cmd_ready, rsp_valid, rsp_timeout, rsp_data);
      end
      n_checks++;
      if ({dbg_run, dbg_step, dbg_load, dbg_dump, dbg_shift_in, dbg_reg_sel} !== 7'b0) begin
         n_fail++; $display("FAIL mid_rst_dbg: got %b expected 0000000",
                            {dbg_run, dbg_step, dbg_load, dbg_dump, dbg_shift_in, dbg_reg_sel});
      end
      @(negedge clk);
      rst = 1'b0;
      record(20);
      n_checks++;
      if (m_rv[19:0] !== 20'h0 || m_dump[19:0] !== 20'h0) begin
         n_fail++; $display("FAIL mid_rst_quiet: got rv=%h dump=%h expected 0 0", m_rv[19:0], m_dump[19:0]);
      end
      start_cmd(2'd0, 2'd0, 8'h5A, 1'b0);
      record(16);
      n_checks++;
      if (rec_cyc != 9 || m_load[15:0] !== 16'h0100) begin
         n_fail++; $display("FAIL post_rst_wr: got cycle %0d load=%h expected 9 0100", rec_cyc, m_load[15:0]);
      end
      start_cmd(2'd1, 2'd0, 8'h00, 1'b0);
      record(16);
      n_checks++;
      if (rec_data !== 8'h5A) begin
         n_fail++; $display("FAIL post_rst_rd: got %h expected 5a", rec_data);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = 2'd0;
      cmd_reg   = 2'd0;
      cmd_data  = 8'h00;
      cmd_wait  = 1'b0;
      repeat (3) @(posedge clk);
      test_reset();
      test_write_pc();
      test_read_sp();
      test_round_trip();
      test_exec_wait();
      test_timeout();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
